// File: rtl/centroid_tracker_pkg.sv
// Shared types for the centroid tracker: FSM states, default widths,
// the divider snapshot bundle and a saturating accumulator add.
package centroid_pkg;

  localparam int DEF_H_W   = 11;
  localparam int DEF_V_W   = 10;
  localparam int DEF_SUM_W = 32;
  localparam int DEF_CNT_W = 20;

  typedef enum logic [1:0] {
    ACCUM,
    DIVIDE,
    PUBLISH
  } state_t;

  typedef struct packed {
    logic [DEF_SUM_W-1:0] sum_x;
    logic [DEF_SUM_W-1:0] sum_y;
    logic [DEF_CNT_W-1:0] count;
  } snap_t;

  // Accumulators pin at all-ones instead of wrapping.
  function automatic logic [DEF_SUM_W-1:0] sat_add(input logic [DEF_SUM_W-1:0] a,
                                                   input logic [DEF_SUM_W-1:0] b);
    logic [DEF_SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEF_SUM_W] ? {DEF_SUM_W{1'b1}} : s[DEF_SUM_W-1:0];
  endfunction

endpackage

// File: rtl/centroid_tracker_if.sv
// Pixel-in / centroid-out bundle of the centroid tracker.
// CENTROID_BBOX_EN adds the bounding-box outputs.
interface centroid_tracker_if #(
  parameter int H_W = centroid_pkg::DEF_H_W,
  parameter int V_W = centroid_pkg::DEF_V_W
);
  logic [H_W-1:0] x_in;
  logic [V_W-1:0] y_in;
  logic           valid_in;
  logic           tabulate_in;
  logic [H_W-1:0] x_out;
  logic [V_W-1:0] y_out;
  logic           valid_out;
  logic           busy_out;
`ifdef CENTROID_BBOX_EN
  logic [H_W-1:0] x_min_out;
  logic [H_W-1:0] x_max_out;
  logic [V_W-1:0] y_min_out;
  logic [V_W-1:0] y_max_out;

  modport slave (
    input  x_in, y_in, valid_in, tabulate_in,
    output x_out, y_out, valid_out, busy_out,
    output x_min_out, x_max_out, y_min_out, y_max_out
  );
  modport master (
    output x_in, y_in, valid_in, tabulate_in,
    input  x_out, y_out, valid_out, busy_out,
    input  x_min_out, x_max_out, y_min_out, y_max_out
  );
`else
  modport slave (
    input  x_in, y_in, valid_in, tabulate_in,
    output x_out, y_out, valid_out, busy_out
  );
  modport master (
    output x_in, y_in, valid_in, tabulate_in,
    input  x_out, y_out, valid_out, busy_out
  );
`endif
endinterface

// File: rtl/centroid_tracker_seq_divider.sv
// Restoring divider, one quotient bit per cycle for exactly SUM_W cycles.
// Operands must stay stable while running; only the low Q_W quotient bits are kept.
module seq_divider #(
  parameter int SUM_W = 32,
  parameter int Q_W   = 11
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);
  localparam int CB = $clog2(SUM_W);

  logic [CB-1:0]    r_cnt;
  logic             r_run;
  logic [SUM_W-1:0] r_rem;
  logic [Q_W-1:0]   r_quo;

  logic [CB-1:0]    w_bit_idx;
  logic [SUM_W:0]   w_trial;
  logic             w_fit;
  logic [SUM_W-1:0] w_diff;

  // Dividend bits are consumed MSB first straight from the stable input.
  assign w_bit_idx = CB'(SUM_W - 1) - r_cnt;
  assign w_trial   = {r_rem, dividend[w_bit_idx]};
  assign w_fit     = w_trial[SUM_W] || (w_trial[SUM_W-1:0] >= divisor);
  assign w_diff    = w_trial[SUM_W-1:0] - divisor;
  assign done      = r_run && (r_cnt == CB'(SUM_W - 1));
  assign quotient  = r_quo;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_rem <= '0;
      r_quo <= '0;
    end else if (start) begin
      r_cnt <= '0;
      r_run <= 1'b1;
      r_rem <= '0;
      r_quo <= '0;
    end else if (r_run) begin
      r_rem <= w_fit ? w_diff : w_trial[SUM_W-1:0];
      r_quo <= {r_quo[Q_W-2:0], w_fit};
      r_cnt <= r_cnt + CB'(1);
      if (done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/centroid_tracker.sv
// Per-frame centre of mass of mask pixels, divided iteratively after each frame-end strobe.
// Define CENTROID_BBOX_EN to also publish the per-frame bounding box.
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int H_W   = DEF_H_W,
  parameter int V_W   = DEF_V_W,
  parameter int SUM_W = DEF_SUM_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic               clk_in,
  input logic               rst_n_in,
  centroid_tracker_if.slave bus
);
  state_t r_state, w_state_next;
  logic   w_start, w_publish;

  logic [SUM_W-1:0] r_sum_x, r_sum_y;
  logic [CNT_W-1:0] r_count;
  snap_t            r_snap;

  logic [SUM_W-1:0] w_sum_x_incl, w_sum_y_incl;
  logic [CNT_W-1:0] w_cnt_incl;
  logic [H_W-1:0]   w_quo_x;
  logic [V_W-1:0]   w_quo_y;
  logic             w_done_x, w_done_y;

  logic [H_W-1:0] r_x_out;
  logic [V_W-1:0] r_y_out;
  logic           r_valid_out;

  // Running totals including this cycle's pixel, which belongs to the frame being closed.
  assign w_sum_x_incl = bus.valid_in ? sat_add(r_sum_x, SUM_W'(bus.x_in)) : r_sum_x;
  assign w_sum_y_incl = bus.valid_in ? sat_add(r_sum_y, SUM_W'(bus.y_in)) : r_sum_y;
  assign w_cnt_incl   = (bus.valid_in && !(&r_count)) ? r_count + CNT_W'(1) : r_count;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_publish    = 1'b0;
    case (r_state)
      ACCUM: begin
        if (bus.tabulate_in && (w_cnt_incl != '0)) begin
          w_start      = 1'b1;
          w_state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        if (w_done_x && w_done_y) w_state_next = PUBLISH;
      end
      PUBLISH: begin
        w_publish    = 1'b1;
        w_state_next = ACCUM;
      end
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ACCUM;
    else           r_state <= w_state_next;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_count <= '0;
      r_snap  <= '0;
    end else begin
      if (bus.tabulate_in) begin
        r_sum_x <= '0;
        r_sum_y <= '0;
        r_count <= '0;
      end else begin
        r_sum_x <= w_sum_x_incl;
        r_sum_y <= w_sum_y_incl;
        r_count <= w_cnt_incl;
      end
      if (w_start) begin
        r_snap.sum_x <= w_sum_x_incl;
        r_snap.sum_y <= w_sum_y_incl;
        r_snap.count <= w_cnt_incl;
      end
    end
  end

  seq_divider #(.SUM_W(SUM_W), .Q_W(H_W)) u_div_x (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start    (w_start),
    .dividend (r_snap.sum_x),
    .divisor  (SUM_W'(r_snap.count)),
    .quotient (w_quo_x),
    .done     (w_done_x)
  );

  seq_divider #(.SUM_W(SUM_W), .Q_W(V_W)) u_div_y (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start    (w_start),
    .dividend (r_snap.sum_y),
    .divisor  (SUM_W'(r_snap.count)),
    .quotient (w_quo_y),
    .done     (w_done_y)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_publish;
      if (w_publish) begin
        r_x_out <= w_quo_x;
        r_y_out <= w_quo_y;
      end
    end
  end

  assign bus.x_out     = r_x_out;
  assign bus.y_out     = r_y_out;
  assign bus.valid_out = r_valid_out;
  assign bus.busy_out  = (r_state == DIVIDE);

`ifdef CENTROID_BBOX_EN
  logic [H_W-1:0] r_x_min, r_x_max, r_snap_x_min, r_snap_x_max, r_x_min_out, r_x_max_out;
  logic [V_W-1:0] r_y_min, r_y_max, r_snap_y_min, r_snap_y_max, r_y_min_out, r_y_max_out;
  logic [H_W-1:0] w_x_min_incl, w_x_max_incl;
  logic [V_W-1:0] w_y_min_incl, w_y_max_incl;

  assign w_x_min_incl = (bus.valid_in && bus.x_in < r_x_min) ? bus.x_in : r_x_min;
  assign w_x_max_incl = (bus.valid_in && bus.x_in > r_x_max) ? bus.x_in : r_x_max;
  assign w_y_min_incl = (bus.valid_in && bus.y_in < r_y_min) ? bus.y_in : r_y_min;
  assign w_y_max_incl = (bus.valid_in && bus.y_in > r_y_max) ? bus.y_in : r_y_max;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_x_min      <= '1;
      r_x_max      <= '0;
      r_y_min      <= '1;
      r_y_max      <= '0;
      r_snap_x_min <= '1;
      r_snap_x_max <= '0;
      r_snap_y_min <= '1;
      r_snap_y_max <= '0;
      r_x_min_out  <= '0;
      r_x_max_out  <= '0;
      r_y_min_out  <= '0;
      r_y_max_out  <= '0;
    end else begin
      if (bus.tabulate_in) begin
        r_x_min <= '1;
        r_x_max <= '0;
        r_y_min <= '1;
        r_y_max <= '0;
      end else begin
        r_x_min <= w_x_min_incl;
        r_x_max <= w_x_max_incl;
        r_y_min <= w_y_min_incl;
        r_y_max <= w_y_max_incl;
      end
      if (w_start) begin
        r_snap_x_min <= w_x_min_incl;
        r_snap_x_max <= w_x_max_incl;
        r_snap_y_min <= w_y_min_incl;
        r_snap_y_max <= w_y_max_incl;
      end
      if (w_publish) begin
        r_x_min_out <= r_snap_x_min;
        r_x_max_out <= r_snap_x_max;
        r_y_min_out <= r_snap_y_min;
        r_y_max_out <= r_snap_y_max;
      end
    end
  end

  assign bus.x_min_out = r_x_min_out;
  assign bus.x_max_out = r_x_max_out;
  assign bus.y_min_out = r_y_min_out;
  assign bus.y_max_out = r_y_max_out;
`endif

endmodule

// File: tb/tb_centroid_tracker.sv
// Scoreboard bench for centroid_tracker: a frame model pushes expected centroids
// at each strobe; a monitor pops and compares them on every valid_out pulse.
module tb_centroid_tracker;
  import centroid_pkg::*;

  localparam int H_W = 11;
  localparam int V_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  centroid_tracker_if #(.H_W(H_W), .V_W(V_W)) bus ();

  centroid_tracker #(.H_W(H_W), .V_W(V_W), .SUM_W(32), .CNT_W(20)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int x;
    int y;
    int xmin;
    int xmax;
    int ymin;
    int ymax;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Frame model: plain integer sums, divided when the strobe is driven.
  int m_sx, m_sy, m_n, m_xmin, m_xmax, m_ymin, m_ymax;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_sx = 0; m_sy = 0; m_n = 0;
    m_xmin = (1 << H_W) - 1; m_xmax = 0;
    m_ymin = (1 << V_W) - 1; m_ymax = 0;
  endtask

  // Drives one pixel-clock worth of inputs; expect_pub=0 marks a strobe the DUT must drop.
  task automatic pix(input int x, input int y, input bit v, input bit t, input bit expect_pub);
    exp_t e;
    @(negedge clk);
    bus.x_in = H_W'(x);
    bus.y_in = V_W'(y);
    bus.valid_in = v;
    bus.tabulate_in = t;
    if (v) begin
      m_sx += x; m_sy += y; m_n++;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end
    if (t) begin
      if (expect_pub && m_n != 0) begin
        e.x = m_sx / m_n; e.y = m_sy / m_n;
        e.xmin = m_xmin; e.xmax = m_xmax; e.ymin = m_ymin; e.ymax = m_ymax;
        sb_q.push_back(e);
      end
      model_clear();
    end
  endtask

  // Counts edges from the strobe-sampling edge (n=1) until valid_out rises.
  task automatic wait_pub(input int exp_lat, input string tag);
    bit seen = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin bus.tabulate_in = 1'b0; bus.valid_in = 1'b0; end
      if (n == 2) check_eq({tag, "_busy"}, bus.busy_out, 1);
      if (bus.valid_out === 1'b1) begin
        seen = 1;
        check_eq({tag, "_latency"}, n, exp_lat);
        break;
      end
    end
    check_eq({tag, "_published"}, seen, 1);
  endtask

  // Watches a window where nothing must publish.
  task automatic quiet(input int cycles, input string tag, input bit chk_busy);
    bit seen_v = 0;
    bit seen_b = 0;
    for (int n = 1; n <= cycles; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin bus.tabulate_in = 1'b0; bus.valid_in = 1'b0; end
      seen_v |= bus.valid_out;
      seen_b |= bus.busy_out;
    end
    check_eq({tag, "_no_valid"}, seen_v, 0);
    if (chk_busy) check_eq({tag, "_no_busy"}, seen_b, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_valid", bus.valid_out, 0);
      end else begin
        e = sb_q.pop_front();
        $display("publish x=%0d y=%0d (expected %0d,%0d)", bus.x_out, bus.y_out, e.x, e.y);
        check_eq("x_out", bus.x_out, e.x);
        check_eq("y_out", bus.y_out, e.y);
`ifdef CENTROID_BBOX_EN
        check_eq("x_min_out", bus.x_min_out, e.xmin);
        check_eq("x_max_out", bus.x_max_out, e.xmax);
        check_eq("y_min_out", bus.y_min_out, e.ymin);
        check_eq("y_max_out", bus.y_max_out, e.ymax);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.x_in = '0; bus.y_in = '0; bus.valid_in = 1'b0; bus.tabulate_in = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_x_out", bus.x_out, 0);
    check_eq("rst_y_out", bus.y_out, 0);
    check_eq("rst_valid_out", bus.valid_out, 0);
    check_eq("rst_busy_out", bus.busy_out, 0);
    rst_n = 1'b1;

    // Single hit pixel.
    pix(100, 50, 1, 0, 1);
    pix(0, 0, 0, 1, 1);
    wait_pub(34, "single");

    // Three hits, floor division of 61/3.
    pix(10, 20, 1, 0, 1);
    pix(11, 20, 1, 0, 1);
    pix(12, 21, 1, 0, 1);
    pix(0, 0, 0, 1, 1);
    wait_pub(34, "three");

    // Empty frame: no publish, no divide, outputs hold.
    pix(0, 0, 0, 1, 1);
    quiet(45, "empty", 1);
    check_eq("empty_hold_x", bus.x_out, 11);
    check_eq("empty_hold_y", bus.y_out, 20);

    // Hit in the same cycle as the strobe belongs to the closed frame.
    pix(100, 100, 1, 0, 1);
    pix(200, 100, 1, 1, 1);
    wait_pub(34, "same_cycle");

    // Second strobe mid-divide is dropped along with the pixels before it.
    pix(30, 40, 1, 0, 1);
    pix(0, 0, 0, 1, 1);
    repeat (4) pix(500, 500, 1, 0, 0);
    pix(0, 0, 0, 1, 0);
    wait_pub(29, "early_strobe");
    pix(60, 70, 1, 0, 1);
    pix(62, 70, 1, 0, 1);
    pix(0, 0, 0, 1, 1);
    wait_pub(34, "after_drop");

    // Reset ten cycles into the divide aborts it.
    pix(300, 200, 1, 0, 0);
    pix(0, 0, 0, 1, 0);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin bus.tabulate_in = 1'b0; bus.valid_in = 1'b0; end
    end
    rst_n = 1'b0;
    #2;
    check_eq("abort_x_out", bus.x_out, 0);
    check_eq("abort_y_out", bus.y_out, 0);
    check_eq("abort_busy_out", bus.busy_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(50, "abort", 1);

    // Two spread hits; bounding box (5,2)-(40,7) when enabled.
    pix(5, 7, 1, 0, 1);
    pix(40, 2, 1, 0, 1);
    pix(0, 0, 0, 1, 1);
    wait_pub(34, "bbox");

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
